// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Control states: waiting, processing one bit per cycle, result pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow generate/propagate.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             bit_d, bit_bo;
  logic [WIDTH-1:0] res_next;

  // Current LSBs of the operand shift registers feed the single cell.
  full_subtractor u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // Result fills from the MSB side so after WIDTH shifts bit 0 lands at [0].
  always_comb begin
    res_next = {bit_d, res_q[WIDTH-1:1]};
  end

  // Next-state, datapath and result-register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE, DONE: begin
        // Accepting: a new request starts immediately, even from DONE.
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // start is not looked at here; operands are already captured.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next;
        br_d  = bit_bo;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          diff_d  = res_next;
          bout_d  = bit_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int n_cmp = 0;
  int n_bad = 0;

  // Last result the DUT should be holding.
  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Plain integer subtraction; negative result means a borrow out.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       output logic [W-1:0] d, output logic bo);
    int r;
    r  = int'(ta) - int'(tb_) - int'(tbin);
    d  = W'(r & ((1 << W) - 1));
    bo = (r < 0);
  endtask

  // Issue one op starting at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input bit inject, input string tag);
    logic [W-1:0] ed;
    logic         eb;
    int cyc, bcnt;
    cyc = 0;
    bcnt = 0;
    model(ta, tb_, tbin, ed, eb);
    start = 1'b1; a = ta; b = tb_; bin = tbin;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    while (!done && cyc < 3 * W) begin
      if (busy) bcnt++;
      if (cyc == 1) begin
        check({tag, "_hold_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_hold_bout"}, 32'(bout), 32'(exp_bout));
      end
      start = inject && (cyc == 1);
      if (start) begin
        a = '0; b = '1; bin = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(W));
    check({tag, "_latency"}, 32'(cyc), 32'(W));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    exp_diff = ed;
    exp_bout = eb;
  endtask

  // One cycle after done with start low: idle, pulse gone, result held.
  task automatic idle_after(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_held"}, 32'(diff), 32'(exp_diff));
  endtask

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b1010, 4'b0101, 1'b0, 1'b0, "basic");
    idle_after("basic");
    run_op(4'b1000, 4'b1101, 1'b1, 1'b0, "borrow");
    idle_after("borrow");
    run_op(4'b0000, 4'b1111, 1'b1, 1'b0, "wrap");
    idle_after("wrap");

    // Back-to-back: second op accepted in the first op's done cycle.
    run_op(4'b1101, 4'b0111, 1'b0, 1'b0, "b2b_first");
    run_op(4'b1111, 4'b0001, 1'b0, 1'b0, "b2b_second");
    idle_after("b2b");

    run_op(4'b1010, 4'b0101, 1'b0, 1'b1, "ignore_start");
    idle_after("ignore_start");

    // Reset two cycles into SHIFT.
    start = 1'b1; a = 4'd3; b = 4'd1; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    exp_diff = '0;
    exp_bout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op(4'b0110, 4'b0011, 1'b1, 1'b0, "post_rst");
    idle_after("post_rst");

    // Random operands, randomly back-to-back or with an idle gap.
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 1) == 1) idle_after("rand");
    end
    idle_after("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
